deadtime_gen: RTL and testbench

Gate-drive stage directly downstream of `svm`. Takes the three single-ended phase commands `pwmA/B/C` and produces complementary high-side/low-side gate signals with a programmable dead time. Adds glitch rejection and a fault trip that forces every gate off. Outputs drive the inverter gate drivers directly, so every output is registered and glitch-free.

---
 rtl/deadtime_gen_if.sv | 29 ++
 rtl/deadtime_gen.sv | 120 ++++++++++++
 tb/tb_deadtime_gen.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/deadtime_gen_if.sv
// Gate-drive bundle between the svm command side (master) and deadtime_gen (slave).
// Carries phase commands, period strobe, dead-time request, trip request and gate outputs.
interface deadtime_gen_if #(
  parameter int unsigned DT_WIDTH = 8
) ();
  logic                pwmA;
  logic                pwmB;
  logic                pwmC;
  logic                halt;
  logic [DT_WIDTH-1:0] deadTime;
  logic                fault;
  logic                gateAH;
  logic                gateAL;
  logic                gateBH;
  logic                gateBL;
  logic                gateCH;
  logic                gateCL;
  logic                tripped;

  modport master (
    output pwmA, pwmB, pwmC, halt, deadTime, fault,
    input  gateAH, gateAL, gateBH, gateBL, gateCH, gateCL, tripped
  );

  modport slave (
    input  pwmA, pwmB, pwmC, halt, deadTime, fault,
    output gateAH, gateAL, gateBH, gateBL, gateCH, gateCL, tripped
  );
endinterface

// File: rtl/deadtime_gen.sv
// Three-phase complementary gate driver with programmable dead time, glitch rejection
// and a fault trip that holds all gates off until the next period boundary.
module deadtime_gen #(
  parameter int unsigned DT_WIDTH = 8
) (
  input logic           clk,
  input logic           rstb,
  deadtime_gen_if.slave bus
);
  typedef enum logic [2:0] {StOff, StLo, StDtUp, StHi, StDtDn} state_e;

  localparam logic [DT_WIDTH-1:0] CntOne = DT_WIDTH'(1);

  logic [2:0]                pwmR;
  logic [DT_WIDTH-1:0]       dtReg;
  logic                      tripped;
  state_e [2:0]              stateQ;
  state_e [2:0]              stateD;
  logic [2:0][DT_WIDTH-1:0]  cntQ;
  logic [2:0][DT_WIDTH-1:0]  cntD;
  logic [2:0]                gateH;
  logic [2:0]                gateL;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      pwmR    <= '0;
      dtReg   <= '1;
      tripped <= 1'b0;
    end else begin
      pwmR <= {bus.pwmC, bus.pwmB, bus.pwmA};
      // Zero request clamps to one so a both-off cycle always separates the gates.
      if (bus.halt) begin
        dtReg <= (bus.deadTime == '0) ? CntOne : bus.deadTime;
      end
      if (bus.fault) begin
        tripped <= 1'b1;
      end else if (bus.halt) begin
        tripped <= 1'b0;
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    for (int p = 0; p < 3; p++) begin
      if (bus.fault) begin
        stateD[p] = StOff;
      end else begin
        unique case (stateQ[p])
          // Leaving OFF uses the pre-load dtReg; trip release happens on this same edge.
          StOff: begin
            if (bus.halt) begin
              stateD[p] = pwmR[p] ? StDtUp : StDtDn;
              cntD[p]   = dtReg;
            end
          end
          StLo: begin
            if (pwmR[p]) begin
              stateD[p] = StDtUp;
              cntD[p]   = dtReg;
            end
          end
          StDtUp: begin
            if (!pwmR[p]) begin
              stateD[p] = StLo;
            end else if (cntQ[p] <= CntOne) begin
              stateD[p] = StHi;
            end else begin
              cntD[p] = cntQ[p] - CntOne;
            end
          end
          StHi: begin
            if (!pwmR[p]) begin
              stateD[p] = StDtDn;
              cntD[p]   = dtReg;
            end
          end
          StDtDn: begin
            if (pwmR[p]) begin
              stateD[p] = StHi;
            end else if (cntQ[p] <= CntOne) begin
              stateD[p] = StLo;
            end else begin
              cntD[p] = cntQ[p] - CntOne;
            end
          end
          default: stateD[p] = StOff;
        endcase
      end
    end
  end

  // Gates are decoded from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int p = 0; p < 3; p++) begin
        stateQ[p] <= StOff;
        cntQ[p]   <= '0;
      end
      gateH <= '0;
      gateL <= '0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        stateQ[p] <= stateD[p];
        cntQ[p]   <= cntD[p];
        gateH[p]  <= (stateD[p] == StHi);
        gateL[p]  <= (stateD[p] == StLo);
      end
    end
  end

  assign bus.gateAH  = gateH[0];
  assign bus.gateAL  = gateL[0];
  assign bus.gateBH  = gateH[1];
  assign bus.gateBL  = gateL[1];
  assign bus.gateCH  = gateH[2];
  assign bus.gateCL  = gateL[2];
  assign bus.tripped = tripped;
endmodule

// File: tb/tb_deadtime_gen.sv
// Directed and randomized bench for deadtime_gen against a deadline-based behavioural model.
module tb_deadtime_gen;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rstb;
  always #5 clk = ~clk;

  deadtime_gen_if #(.DT_WIDTH(DW)) bus ();
  deadtime_gen #(.DT_WIDTH(DW)) dut (.clk(clk), .rstb(rstb), .bus(bus));

  int unsigned nRun  = 0;
  int unsigned nFail = 0;
  string       tag   = "init";

  // Model: each phase is off, has a gate on (side), or waits for a deadline toward side.
  localparam int ModeOff = 0, ModeOn = 1, ModeWait = 2;
  int       cyc;
  int       mDt;
  bit       mTrip;
  bit [2:0] mPwmR;
  int       mMode [3];
  bit       mSide [3];
  int       mDeadline [3];

  task automatic modelReset();
    mDt   = 255;
    mTrip = 1'b0;
    mPwmR = '0;
    for (int p = 0; p < 3; p++) begin
      mMode[p] = ModeOff;
      mSide[p] = 1'b0;
      mDeadline[p] = 0;
    end
  endtask

  task automatic modelEdge(input bit [2:0] pwm, input bit halt, input bit fault, input int dt);
    cyc++;
    for (int p = 0; p < 3; p++) begin
      if (fault) begin
        mMode[p] = ModeOff;
      end else if (mMode[p] == ModeOff) begin
        if (halt) begin
          mMode[p] = ModeWait;
          mSide[p] = mPwmR[p];
          mDeadline[p] = cyc + mDt;
        end
      end else if (mMode[p] == ModeOn) begin
        if (mPwmR[p] != mSide[p]) begin
          mMode[p] = ModeWait;
          mSide[p] = mPwmR[p];
          mDeadline[p] = cyc + mDt;
        end
      end else begin
        if (mPwmR[p] != mSide[p]) begin
          mMode[p] = ModeOn;
          mSide[p] = mPwmR[p];
        end else if (cyc == mDeadline[p]) begin
          mMode[p] = ModeOn;
        end
      end
    end
    if (fault) mTrip = 1'b1;
    else if (halt) mTrip = 1'b0;
    if (halt) mDt = ((dt % 256) == 0) ? 1 : (dt % 256);
    mPwmR = pwm;
  endtask

  task automatic check();
    logic [2:0] dH;
    logic [2:0] dL;
    bit   [1:0] expHL;
    dH = {bus.gateCH, bus.gateBH, bus.gateAH};
    dL = {bus.gateCL, bus.gateBL, bus.gateAL};
    for (int p = 0; p < 3; p++) begin
      expHL = {(mMode[p] == ModeOn) && mSide[p], (mMode[p] == ModeOn) && !mSide[p]};
      nRun++;
      assert ({dH[p], dL[p]} === expHL) else begin
        nFail++;
        $error("FAIL %s cyc%0d phase%0d gates HL observed %b%b expected %b", tag, cyc, p,
               dH[p], dL[p], expHL);
      end
      nRun++;
      assert (!(dH[p] === 1'b1 && dL[p] === 1'b1)) else begin
        nFail++;
        $error("FAIL %s cyc%0d phase%0d overlap observed H=%b L=%b expected not both 1",
               tag, cyc, p, dH[p], dL[p]);
      end
    end
    nRun++;
    assert (bus.tripped === mTrip) else begin
      nFail++;
      $error("FAIL %s cyc%0d tripped observed %b expected %b", tag, cyc, bus.tripped, mTrip);
    end
  endtask

  task automatic step(input bit [2:0] pwm, input bit halt, input bit fault, input int dt);
    bus.pwmA     = pwm[0];
    bus.pwmB     = pwm[1];
    bus.pwmC     = pwm[2];
    bus.halt     = halt;
    bus.fault    = fault;
    bus.deadTime = DW'(dt);
    @(posedge clk);
    modelEdge(pwm, halt, fault, dt);
    @(negedge clk);
    check();
  endtask

  task automatic hold(input bit [2:0] pwm, input int n);
    for (int i = 0; i < n; i++) step(pwm, 1'b0, 1'b0, int'($urandom_range(0, 255)));
  endtask

  initial begin
    int period;
    int duty [3];
    bit [2:0] pwm;
    bit flt;
    cyc = 0;
    rstb = 1'b0;
    bus.pwmA = 1'b0; bus.pwmB = 1'b0; bus.pwmC = 1'b0;
    bus.halt = 1'b0; bus.fault = 1'b0; bus.deadTime = '0;
    modelReset();
    repeat (2) @(negedge clk);
    tag = "reset";
    check();
    rstb = 1'b1;
    hold(3'b000, 3);

    // First halt loads 4 but the restart uses the reset value of all-ones.
    tag = "startup";
    step(3'b000, 1'b1, 1'b0, 4);
    hold(3'b000, 258);

    tag = "a_rise";
    hold(3'b001, 10);
    tag = "a_fall";
    hold(3'b000, 10);

    tag = "b_glitch";
    step(3'b010, 1'b0, 1'b0, 0);
    hold(3'b000, 8);

    tag = "b_short";
    hold(3'b010, 3);
    hold(3'b000, 8);

    tag = "dt_zero";
    step(3'b000, 1'b1, 1'b0, 0);
    hold(3'b111, 4);
    hold(3'b000, 4);
    hold(3'b101, 3);
    hold(3'b010, 3);

    tag = "fault";
    step(3'b010, 1'b1, 1'b0, 4);
    hold(3'b001, 10);
    hold(3'b011, 2);
    step(3'b011, 1'b0, 1'b1, 0);
    hold(3'b011, 5);
    step(3'b011, 1'b1, 1'b1, 4);
    hold(3'b011, 3);
    tag = "restart";
    step(3'b011, 1'b1, 1'b0, 4);
    hold(3'b011, 8);

    // Asynchronous reset in the middle of a dead-time interval.
    tag = "mid_reset";
    hold(3'b001, 2);
    #2 rstb = 1'b0;
    #1 modelReset();
    check();
    @(negedge clk);
    rstb = 1'b1;
    step(3'b000, 1'b1, 1'b0, 3);
    hold(3'b000, 258);

    // svm-like operation: fixed then random duties, random dead time, rare faults.
    tag = "svm";
    period = 32;
    duty[0] = 24; duty[1] = 8; duty[2] = 16;
    for (int n = 0; n < 12; n++) begin
      if (n >= 4) begin
        for (int p = 0; p < 3; p++) duty[p] = int'($urandom_range(0, period));
      end
      for (int c = 0; c < period; c++) begin
        for (int p = 0; p < 3; p++) pwm[p] = (c < duty[p]);
        flt = (n >= 6) && ($urandom_range(0, 79) == 0);
        step(pwm, c == 0, flt, int'($urandom_range(0, 5)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end
endmodule
